// File: rtl/hsc_ddr2_pkg.sv
// Shared constants and helpers for the DDR2 pattern tester slice.
package hsc_ddr2_pkg;

  // Tester state encoding
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_WLOAD = 4'd1;
  localparam logic [3:0] S_WRITE = 4'd2;
  localparam logic [3:0] S_DRAIN = 4'd3;
  localparam logic [3:0] S_RLOAD = 4'd4;
  localparam logic [3:0] S_READ  = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;

  typedef enum logic [3:0] {
    ST_IDLE  = S_IDLE,
    ST_WLOAD = S_WLOAD,
    ST_WRITE = S_WRITE,
    ST_DRAIN = S_DRAIN,
    ST_RLOAD = S_RLOAD,
    ST_READ  = S_READ,
    ST_DONE  = S_DONE
  } state_e;

  // Galois taps for x^32 + x^22 + x^2 + x + 1, right-shifting form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // Pattern modes
  localparam logic PAT_INC  = 1'b0;
  localparam logic PAT_LFSR = 1'b1;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
  endfunction

endpackage

// File: rtl/hsc_pattern_gen.sv
// Pattern word generator: incrementing index or Galois LFSR.
// One instance drives the writer, an independent one regenerates for the checker.
module hsc_pattern_gen
  import hsc_ddr2_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        enable,
  input  logic [31:0] seed,
  input  logic        mode,
  output logic [31:0] word
);

  logic [23:0] cnt_q, cnt_d;
  logic [31:0] lfsr_q, lfsr_d;

  // Next index / LFSR state: load restarts the sequence, enable steps it
  always_comb begin
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if (load) begin
      cnt_d  = 24'd0;
      lfsr_d = seed_fix(seed);
    end else if (enable) begin
      cnt_d  = cnt_q + 24'd1;
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      cnt_d  = cnt_q;
      lfsr_d = lfsr_q;
    end
  end

  // Generator state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 24'd0;
      lfsr_q <= 32'h0000_0001;
    end else begin
      cnt_q  <= cnt_d;
      lfsr_q <= lfsr_d;
    end
  end

  assign word = (mode == PAT_LFSR) ? lfsr_q : {8'h00, cnt_q};

endmodule

// File: rtl/hsc_ddr2_pattern_tester.sv
// DDR2 path pattern tester: writes LEN pattern words through the write FIFO,
// waits for the write path to drain, reads them back and checks each word.
module hsc_ddr2_pattern_tester
  import hsc_ddr2_pkg::*;
#(
  parameter logic [31:0] SEED      = 32'hACE1_2019,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned DRAIN_CYC = 1024,
  parameter int unsigned LOAD_CYC  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mode,
  input  logic [23:0] len,
  input  logic        wr_full,
  input  logic        rd_avail,
  output logic        wr_req,
  output logic [31:0] wr_data,
  output logic        wr_load,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  output logic        rd_load,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_cnt,
  output logic [23:0] first_err_idx
);

  // Load phase: LOAD_CYC pulse cycles followed by two quiet cycles
  localparam logic [23:0] LOAD_W     = 24'(LOAD_CYC);
  localparam logic [23:0] LOAD_LAST  = 24'(LOAD_CYC + 32'd1);
  localparam logic [23:0] DRAIN_LAST = 24'(DRAIN_CYC - 32'd1);
  localparam logic [23:0] NO_ERR     = 24'hFF_FFFF;

  state_e      state_q, state_d;
  logic        mode_q, mode_d;
  logic [23:0] len_q, len_d;
  logic [23:0] wr_idx_q, wr_idx_d;
  logic [23:0] rq_idx_q, rq_idx_d;
  logic [23:0] chk_idx_q, chk_idx_d;
  logic [23:0] cnt_q, cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic [23:0] first_err_idx_q, first_err_idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic        wr_load_q, wr_load_d;
  logic        rd_load_q, rd_load_d;
  logic [RD_LAT-1:0]       vld_q, vld_d;
  logic [RD_LAT-1:0][31:0] exp_q, exp_d;

  logic        wr_push_s;
  logic        rd_pop_s;
  logic        cmp_s;
  logic        mism_s;
  logic [31:0] wr_word_s;
  logic [31:0] rd_word_s;

  assign wr_push_s = (state_q == ST_WRITE) && (wr_idx_q != len_q) && !wr_full;
  assign rd_pop_s  = (state_q == ST_READ) && (rq_idx_q != len_q) && rd_avail;
  assign cmp_s     = (state_q == ST_READ) && vld_q[RD_LAT-1];
  assign mism_s    = cmp_s && (rd_data != exp_q[RD_LAT-1]);

  hsc_pattern_gen u_wr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ST_WLOAD),
    .enable (wr_push_s),
    .seed   (SEED),
    .mode   (mode_q),
    .word   (wr_word_s)
  );

  hsc_pattern_gen u_rd_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (state_q == ST_RLOAD),
    .enable (rd_pop_s),
    .seed   (SEED),
    .mode   (mode_q),
    .word   (rd_word_s)
  );

  // Sequencer next-state, counters, check pipeline and output decode
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    len_d           = len_q;
    wr_idx_d        = wr_idx_q;
    rq_idx_d        = rq_idx_q;
    chk_idx_d       = chk_idx_q;
    cnt_d           = cnt_q;
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          mode_d          = mode;
          len_d           = len;
          wr_idx_d        = 24'd0;
          rq_idx_d        = 24'd0;
          chk_idx_d       = 24'd0;
          cnt_d           = 24'd0;
          err_cnt_d       = 16'd0;
          first_err_idx_d = NO_ERR;
          if (len == 24'd0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WLOAD;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_WLOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_WRITE;
          cnt_d   = 24'd0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_WRITE: begin
        if (wr_idx_q == len_q) begin
          state_d = ST_DRAIN;
          cnt_d   = 24'd0;
        end else if (wr_push_s) begin
          wr_idx_d = wr_idx_q + 24'd1;
        end else begin
          wr_idx_d = wr_idx_q;
        end
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = ST_RLOAD;
          cnt_d   = 24'd0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_RLOAD: begin
        if (cnt_q == LOAD_LAST) begin
          state_d = ST_READ;
          cnt_d   = 24'd0;
        end else begin
          cnt_d = cnt_q + 24'd1;
        end
      end
      ST_READ: begin
        if (rd_pop_s) begin
          rq_idx_d = rq_idx_q + 24'd1;
        end else begin
          rq_idx_d = rq_idx_q;
        end
        if (cmp_s) begin
          chk_idx_d = chk_idx_q + 24'd1;
        end else begin
          chk_idx_d = chk_idx_q;
        end
        if (mism_s) begin
          if (err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end else begin
            err_cnt_d = err_cnt_q;
          end
          if (first_err_idx_q == NO_ERR) begin
            first_err_idx_d = chk_idx_q;
          end else begin
            first_err_idx_d = first_err_idx_q;
          end
        end else begin
          err_cnt_d = err_cnt_q;
        end
        if (chk_idx_q == len_q) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_READ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Expected word travels alongside the pop so it lines up with rd_data
    vld_d    = vld_q;
    exp_d    = exp_q;
    vld_d[0] = rd_pop_s;
    exp_d[0] = rd_word_s;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      exp_d[i] = exp_q[i-1];
    end

    wr_load_d = (state_d == ST_WLOAD) && (cnt_d < LOAD_W);
    rd_load_d = (state_d == ST_RLOAD) && (cnt_d < LOAD_W);
    busy_d    = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d    = (state_d == ST_DONE);
    pass_d    = done_d && (err_cnt_d == 16'd0);
  end

  // Sequencer and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      mode_q          <= PAT_INC;
      len_q           <= 24'd0;
      wr_idx_q        <= 24'd0;
      rq_idx_q        <= 24'd0;
      chk_idx_q       <= 24'd0;
      cnt_q           <= 24'd0;
      err_cnt_q       <= 16'd0;
      first_err_idx_q <= NO_ERR;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      pass_q          <= 1'b0;
      wr_load_q       <= 1'b0;
      rd_load_q       <= 1'b0;
      vld_q           <= {RD_LAT{1'b0}};
      exp_q           <= {RD_LAT{32'h0000_0000}};
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      len_q           <= len_d;
      wr_idx_q        <= wr_idx_d;
      rq_idx_q        <= rq_idx_d;
      chk_idx_q       <= chk_idx_d;
      cnt_q           <= cnt_d;
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      pass_q          <= pass_d;
      wr_load_q       <= wr_load_d;
      rd_load_q       <= rd_load_d;
      vld_q           <= vld_d;
      exp_q           <= exp_d;
    end
  end

  // FIFO handshakes follow the live full/avail flags so no push or pop is lost
  assign wr_req        = wr_push_s;
  assign wr_data       = (state_q == ST_WRITE) ? wr_word_s : 32'h0000_0000;
  assign rd_req        = rd_pop_s;
  assign wr_load       = wr_load_q;
  assign rd_load       = rd_load_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;

endmodule

// File: tb/tb_hsc_ddr2_pattern_tester.sv
// Directed bench for hsc_ddr2_pattern_tester with a simple FIFO/DDR2 model.
module tb_hsc_ddr2_pattern_tester;

  localparam int          RD_LAT    = 2;
  localparam int          DRAIN_CYC = 40;
  localparam logic [31:0] SEED      = 32'hACE1_2019;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [23:0] len = 24'd0;
  logic        wr_full;
  logic        rd_avail;
  logic        wr_req;
  logic [31:0] wr_data;
  logic        wr_load;
  logic        rd_req;
  logic [31:0] rd_data = 32'h0;
  logic        rd_load;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] err_cnt;
  logic [23:0] first_err_idx;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  hsc_ddr2_pattern_tester #(
    .SEED      (SEED),
    .RD_LAT    (RD_LAT),
    .DRAIN_CYC (DRAIN_CYC),
    .LOAD_CYC  (4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .len           (len),
    .wr_full       (wr_full),
    .rd_avail      (rd_avail),
    .wr_req        (wr_req),
    .wr_data       (wr_data),
    .wr_load       (wr_load),
    .rd_req        (rd_req),
    .rd_data       (rd_data),
    .rd_load       (rd_load),
    .busy          (busy),
    .done          (done),
    .pass          (pass),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx)
  );

  // ---------------- ideal DDR2 round-trip model ----------------
  logic [31:0] mem [0:1023];
  int          wptr = 0, rptr = 0;
  int          push_tot = 0, bad_push = 0, pop_tot = 0, wl_tot = 0, rl_tot = 0;
  logic [31:0] ref_lfsr = 32'h0;
  int          ref_idx = 0;
  logic [31:0] push0 = 32'h0, push1 = 32'h0;
  logic        full_en = 1'b0, full_r = 1'b0;
  int          tog = 0;
  logic        gap_en = 1'b0;
  int          hole = 0;
  int          cor_a = -1, cor_b = -1;
  logic        cur_mode = 1'b0;
  logic [31:0] rd_p1 = 32'h0;

  assign wr_full  = full_en & full_r;
  assign rd_avail = (rptr < wptr) && (hole == 0);

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  // FIFO storage, reference push checking, read latency and flow-control
  always @(posedge clk) begin
    if (wr_load) begin
      wl_tot   <= wl_tot + 1;
      wptr     <= 0;
      ref_lfsr <= SEED;
      ref_idx  <= 0;
    end else if (wr_req && !wr_full) begin
      mem[wptr] <= wr_data;
      wptr      <= wptr + 1;
      push_tot  <= push_tot + 1;
      if (wr_data !== (cur_mode ? ref_lfsr : {8'h00, ref_idx[23:0]})) bad_push <= bad_push + 1;
      if (ref_idx == 0) push0 <= wr_data;
      if (ref_idx == 1) push1 <= wr_data;
      ref_lfsr <= ref_step(ref_lfsr);
      ref_idx  <= ref_idx + 1;
    end
    if (rd_load) begin
      rl_tot <= rl_tot + 1;
      rptr   <= 0;
    end else if (rd_req) begin
      rd_p1   <= mem[rptr] ^ (((rptr == cor_a) || (rptr == cor_b)) ? 32'h1 : 32'h0);
      rptr    <= rptr + 1;
      pop_tot <= pop_tot + 1;
    end
    rd_data <= rd_p1;
    if (tog == 2) begin
      tog    <= 0;
      full_r <= ~full_r;
    end else begin
      tog <= tog + 1;
    end
    if (hole > 0) hole <= hole - 1;
    else if (gap_en && ($urandom_range(0, 2) == 0)) hole <= int'($urandom_range(1, 7));
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  int p0, b0, r0, wl0, rl0;
  task automatic snap();
    p0 = push_tot; b0 = bad_push; r0 = pop_tot; wl0 = wl_tot; rl0 = rl_tot;
  endtask

  task automatic run_start(input logic m, input logic [23:0] l);
    @(negedge clk);
    mode = m; len = l; cur_mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_pass"}, {31'd0, pass}, 32'd0);
    check({tag, "_err"}, {16'd0, err_cnt}, 32'd0);
    check({tag, "_fei"}, {8'd0, first_err_idx}, 32'h00FF_FFFF);
    check({tag, "_wrreq"}, {31'd0, wr_req}, 32'd0);
    check({tag, "_wrdata"}, wr_data, 32'd0);
    check({tag, "_wrload"}, {31'd0, wr_load}, 32'd0);
    check({tag, "_rdreq"}, {31'd0, rd_req}, 32'd0);
    check({tag, "_rdload"}, {31'd0, rd_load}, 32'd0);
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;

    // 1: incrementing pattern, ideal path; a start while busy is ignored
    snap();
    run_start(1'b0, 24'd64);
    repeat (20) @(negedge clk);
    len = 24'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; len = 24'd64;
    wait_done("t1", 3000);
    check("t1_pushes", push_tot - p0, 32'd64);
    check("t1_badpush", bad_push - b0, 32'd0);
    check("t1_pops", pop_tot - r0, 32'd64);
    check("t1_wrload_w", wl_tot - wl0, 32'd4);
    check("t1_rdload_w", rl_tot - rl0, 32'd4);
    check("t1_pass", {31'd0, pass}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd0);
    check("t1_err", {16'd0, err_cnt}, 32'd0);
    check("t1_fei", {8'd0, first_err_idx}, 32'h00FF_FFFF);

    // 2: LFSR pattern with wr_full toggling every 3 cycles
    full_en = 1'b1;
    snap();
    run_start(1'b1, 24'd256);
    wait_done("t2", 5000);
    full_en = 1'b0;
    check("t2_pushes", push_tot - p0, 32'd256);
    check("t2_badpush", bad_push - b0, 32'd0);
    check("t2_word0", push0, 32'hACE1_2019);
    check("t2_word1", push1, 32'hD650_900F);
    check("t2_pass", {31'd0, pass}, 32'd1);

    // 3: words 5 and 20 corrupted on the way back
    cor_a = 5; cor_b = 20;
    run_start(1'b0, 24'd32);
    wait_done("t3", 3000);
    cor_a = -1; cor_b = -1;
    check("t3_err", {16'd0, err_cnt}, 32'd2);
    check("t3_fei", {8'd0, first_err_idx}, 32'd5);
    check("t3_pass", {31'd0, pass}, 32'd0);

    // 4: gapped rd_avail with two-cycle read latency
    gap_en = 1'b1;
    snap();
    run_start(1'b0, 24'd100);
    wait_done("t4", 5000);
    gap_en = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_pops", pop_tot - r0, 32'd100);
    check("t4_err", {16'd0, err_cnt}, 32'd0);
    check("t4_pass", {31'd0, pass}, 32'd1);

    // 5: reset in the middle of the write phase, then a clean run
    snap();
    run_start(1'b0, 24'd40);
    begin
      int k = 0;
      while ((push_tot - p0) < 10 && k < 500) begin
        @(negedge clk);
        k++;
      end
    end
    check("t5_reach", push_tot - p0, 32'd10);
    rst_n = 1'b0;
    #1;
    check_reset_vals("t5_rst");
    @(negedge clk);
    rst_n = 1'b1;
    snap();
    repeat (4) @(negedge clk);
    check("t5_nopulse", wl_tot - wl0, 32'd0);
    check("t5_idle", {31'd0, busy}, 32'd0);
    snap();
    run_start(1'b0, 24'd16);
    wait_done("t5b", 3000);
    check("t5_pushes", push_tot - p0, 32'd16);
    check("t5_pass", {31'd0, pass}, 32'd1);

    // 6: len 0 finishes at once with no traffic
    snap();
    run_start(1'b0, 24'd0);
    check("t6_done", {31'd0, done}, 32'd1);
    check("t6_pass", {31'd0, pass}, 32'd1);
    check("t6_busy", {31'd0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    check("t6_pushes", push_tot - p0, 32'd0);
    check("t6_pops", pop_tot - r0, 32'd0);
    check("t6_wrload", wl_tot - wl0, 32'd0);
    check("t6_rdload", rl_tot - rl0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
